// File: rtl/bsg_noc_link_upsizer.sv
// rtl/bsg_noc_link_upsizer.sv - gathers els_p narrow link beats into one wide word.
// Optional idle flush of partial words: define BSG_NOC_UPSIZER_FLUSH_EN.
module bsg_noc_link_upsizer #(
   parameter int in_width_p   = 8,
   parameter int els_p        = 4,
   parameter int timeout_p    = 16,
   localparam int out_width_lp = in_width_p * els_p,
   localparam int els_width_lp = $clog2(els_p + 1)
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    in_v_i,
   input  logic [in_width_p-1:0]   in_data_i,
   output logic                    in_ready_and_o,
   output logic                    out_v_o,
   output logic [out_width_lp-1:0] out_data_o,
   output logic [els_width_lp-1:0] out_els_o,
   input  logic                    out_ready_and_i
);

   localparam logic [els_width_lp-1:0] last_idx_lp = els_width_lp'(els_p - 1);
   localparam logic [els_width_lp-1:0] els_lp      = els_width_lp'(els_p);

   logic [els_p-1:0][in_width_p-1:0] acc_q;
   logic [els_p-1:0][in_width_p-1:0] word_full;
   logic [els_width_lp-1:0]          cnt_q;
   logic [out_width_lp-1:0]          out_q;
   logic                             out_v_q;
   logic [els_width_lp-1:0]          out_els_q;
   logic                             last_beat;
   logic                             accept;
   logic                             drain;
   logic                             flush;

   assign last_beat      = (cnt_q == last_idx_lp);
   assign in_ready_and_o = ~last_beat | ~out_v_q | out_ready_and_i;
   assign accept         = in_v_i & in_ready_and_o;
   assign drain          = out_v_q & out_ready_and_i;

   // Top slice is never written by the accumulator, so it is simply overlaid.
   always_comb begin
      word_full          = acc_q;
      word_full[els_p-1] = in_data_i;
   end

`ifdef BSG_NOC_UPSIZER_FLUSH_EN
   localparam int idle_width_lp = $clog2(timeout_p + 1);
   localparam logic [idle_width_lp-1:0] timeout_lp = idle_width_lp'(timeout_p);

   logic [idle_width_lp-1:0] idle_q;

   assign flush = ~accept & (idle_q == timeout_lp) & (~out_v_q | out_ready_and_i);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         idle_q <= '0;
      end else if (accept || flush) begin
         idle_q <= '0;
      end else if ((cnt_q != '0) && (idle_q != timeout_lp)) begin
         idle_q <= idle_q + idle_width_lp'(1);
      end
   end
`else
   assign flush = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         acc_q     <= '0;
         cnt_q     <= '0;
         out_q     <= '0;
         out_v_q   <= 1'b0;
         out_els_q <= '0;
      end else begin
         if (drain) begin
            out_v_q <= 1'b0;
         end
         if (accept) begin
            if (last_beat) begin
               out_q     <= word_full;
               out_v_q   <= 1'b1;
               out_els_q <= els_lp;
               cnt_q     <= '0;
               acc_q     <= '0;
            end else begin
               for (int i = 0; i < els_p; i++) begin
                  if (cnt_q == els_width_lp'(i)) begin
                     acc_q[i] <= in_data_i;
                  end
               end
               cnt_q <= cnt_q + els_width_lp'(1);
            end
         end else if (flush) begin
            out_q     <= acc_q;
            out_v_q   <= 1'b1;
            out_els_q <= cnt_q;
            cnt_q     <= '0;
            acc_q     <= '0;
         end
      end
   end

   assign out_v_o    = out_v_q;
   assign out_data_o = out_q;
   assign out_els_o  = out_els_q;

endmodule

// File: tb/tb_bsg_noc_link_upsizer.sv
// tb/tb_bsg_noc_link_upsizer.sv - self-checking bench for bsg_noc_link_upsizer (els_p=4 and els_p=1).
module tb_bsg_noc_link_upsizer;

   localparam int TO = 4;
`ifdef BSG_NOC_UPSIZER_FLUSH_EN
   localparam bit flush_en = 1'b1;
`else
   localparam bit flush_en = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        v4, r4_o, ov4, ordy4;
   logic [7:0]  d4;
   logic [31:0] od4;
   logic [2:0]  oe4;
   logic        v1, r1_o, ov1, ordy1;
   logic [7:0]  d1, od1;
   logic [0:0]  oe1;

   bsg_noc_link_upsizer #(.in_width_p(8), .els_p(4), .timeout_p(TO)) dut4 (
      .clk_i(clk), .reset_n_i(rst_n), .in_v_i(v4), .in_data_i(d4),
      .in_ready_and_o(r4_o), .out_v_o(ov4), .out_data_o(od4), .out_els_o(oe4),
      .out_ready_and_i(ordy4));

   bsg_noc_link_upsizer #(.in_width_p(8), .els_p(1), .timeout_p(TO)) dut1 (
      .clk_i(clk), .reset_n_i(rst_n), .in_v_i(v1), .in_data_i(d1),
      .in_ready_and_o(r1_o), .out_v_o(ov1), .out_data_o(od1), .out_els_o(oe1),
      .out_ready_and_i(ordy1));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: list of accepted beats and one held output word.
   logic [7:0]  m_beats[$];
   bit          m_held;
   logic [31:0] m_word;
   int          m_nels;
   int          m_idle;
   bit          h1;
   logic [7:0]  w1;

   function automatic logic [31:0] pack4();
      logic [31:0] w = '0;
      foreach (m_beats[i]) w[8*i +: 8] = m_beats[i];
      return w;
   endfunction

   task automatic model_tick();
      bit er4, er1;
      if (!rst_n) begin
         m_beats.delete(); m_held = 0; m_idle = 0; h1 = 0;
         chk("rst_ov4", ov4, 0); chk("rst_els4", oe4, 0); chk("rst_od4", od4, 0);
         chk("rst_ov1", ov1, 0); chk("rst_od1", od1, 0);
         return;
      end
      er4 = (m_beats.size() != 3) || !m_held || ordy4;
      chk("m_rdy4", r4_o, er4);
      chk("m_ov4", ov4, m_held);
      if (m_held) begin
         chk("m_od4", od4, m_word);
         chk("m_els4", oe4, m_nels);
      end
      if (m_held && ordy4) m_held = 0;
      if (v4 && er4) begin
         m_beats.push_back(d4);
         m_idle = 0;
         if (m_beats.size() == 4) begin
            m_word = pack4(); m_nels = 4; m_held = 1; m_beats.delete();
         end
      end else if (flush_en && m_idle == TO && !m_held) begin
         m_word = pack4(); m_nels = m_beats.size(); m_held = 1; m_beats.delete(); m_idle = 0;
      end else if (m_beats.size() != 0 && m_idle < TO) begin
         m_idle++;
      end

      er1 = !h1 || ordy1;
      chk("m_rdy1", r1_o, er1);
      chk("m_ov1", ov1, h1);
      if (h1) begin
         chk("m_od1", od1, w1);
         chk("m_els1", oe1, 1);
      end
      if (h1 && ordy1) h1 = 0;
      if (v1 && er1) begin
         w1 = d1; h1 = 1;
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          rst_n;
      bit          v;
      logic [7:0]  d;
      bit          ordy;
      bit          ov;
      logic [31:0] od;
      logic [2:0]  oe;
      bit          rdy;
      bit          cd;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(bit r, bit v, logic [7:0] d, bit o, bit ov, logic [31:0] od,
                               logic [2:0] oe, bit rdy, bit cd);
      vec_t x;
      x.rst_n = r; x.v = v; x.d = d; x.ordy = o; x.ov = ov; x.od = od; x.oe = oe;
      x.rdy = rdy; x.cd = cd;
      vecs.push_back(x);
   endfunction

   initial begin
      int drops, words;
      bit saw;
      logic [31:0] sd;
      logic [2:0]  se;

      rst_n = 0; v4 = 0; d4 = 0; ordy4 = 0; v1 = 0; d1 = 0; ordy1 = 1;

      // reset with activity, then 11..44 back-to-back
      add(0, 1, 8'h9C, 1, 0, 0, 0, 1, 1);
      add(0, 1, 8'h3E, 0, 0, 0, 0, 1, 1);
      add(1, 1, 8'h11, 1, 0, 0, 0, 1, 1);
      add(1, 1, 8'h22, 1, 0, 0, 0, 1, 0);
      add(1, 1, 8'h33, 1, 0, 0, 0, 1, 0);
      add(1, 1, 8'h44, 1, 0, 0, 0, 1, 0);
      add(1, 0, 8'h00, 0, 1, 32'h44332211, 4, 1, 1);
      add(1, 0, 8'h00, 1, 1, 32'h44332211, 4, 1, 1);
      // output stall: one word plus three beats, then backpressure
      add(1, 1, 8'h01, 0, 0, 0, 0, 1, 0);
      add(1, 1, 8'h02, 0, 0, 0, 0, 1, 0);
      add(1, 1, 8'h03, 0, 0, 0, 0, 1, 0);
      add(1, 1, 8'h04, 0, 0, 0, 0, 1, 0);
      add(1, 1, 8'h05, 0, 1, 32'h04030201, 4, 1, 1);
      add(1, 1, 8'h06, 0, 1, 32'h04030201, 4, 1, 1);
      add(1, 1, 8'h07, 0, 1, 32'h04030201, 4, 1, 1);
      add(1, 1, 8'h08, 0, 1, 32'h04030201, 4, 0, 1);
      add(1, 1, 8'h08, 0, 1, 32'h04030201, 4, 0, 1);
      add(1, 1, 8'h08, 1, 1, 32'h04030201, 4, 1, 1);
      add(1, 1, 8'h09, 0, 1, 32'h08070605, 4, 1, 1);
      add(1, 0, 8'h00, 1, 1, 32'h08070605, 4, 1, 1);
      add(1, 0, 8'h00, 1, 0, 0, 0, 1, 0);
      // reset mid-word, then A1..A4
      add(1, 1, 8'h10, 1, 0, 0, 0, 1, 0);
      add(0, 0, 8'h00, 1, 0, 0, 0, 1, 1);
      add(1, 1, 8'hA1, 1, 0, 0, 0, 1, 0);
      add(1, 1, 8'hA2, 1, 0, 0, 0, 1, 0);
      add(1, 1, 8'hA3, 1, 0, 0, 0, 1, 0);
      add(1, 1, 8'hA4, 1, 0, 0, 0, 1, 0);
      add(1, 0, 8'h00, 1, 1, 32'hA4A3A2A1, 4, 1, 1);
      add(1, 0, 8'h00, 1, 0, 0, 0, 1, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         rst_n = vecs[i].rst_n; v4 = vecs[i].v; d4 = vecs[i].d; ordy4 = vecs[i].ordy;
         @(negedge clk);
         chk($sformatf("vec%0d_rdy", i), r4_o, vecs[i].rdy);
         chk($sformatf("vec%0d_ov", i), ov4, vecs[i].ov);
         if (vecs[i].cd) begin
            chk($sformatf("vec%0d_od", i), od4, vecs[i].od);
            chk($sformatf("vec%0d_els", i), oe4, vecs[i].oe);
         end
         model_tick();
         @(posedge clk);
         #1;
      end

      // continuous streaming at full rate
      drops = 0; words = 0;
      v4 = 1; ordy4 = 1;
      for (int i = 0; i < 40; i++) begin
         d4 = 8'($urandom);
         @(negedge clk);
         if (!r4_o) drops++;
         if (ov4 && ordy4) words++;
         model_tick();
         @(posedge clk);
         #1;
      end
      chk("cont_drops", drops, 0);
      chk("cont_words", words, 9);
      v4 = 0;
      step();

      // els_p=1 single beat
      v1 = 1; d1 = 8'h5A; ordy1 = 1;
      step();
      v1 = 0;
      @(negedge clk);
      chk("e1_ov", ov1, 1);
      chk("e1_od", od1, 8'h5A);
      model_tick();
      @(posedge clk);
      #1;

      // randomized traffic on both instances
      for (int i = 0; i < 3000; i++) begin
         v4 = ($urandom_range(0, 9) < 7); d4 = 8'($urandom); ordy4 = ($urandom_range(0, 9) < 6);
         v1 = ($urandom_range(0, 9) < 6); d1 = 8'($urandom); ordy1 = ($urandom_range(0, 9) < 5);
         step();
      end

      // idle flush of a partial word
      rst_n = 0; v4 = 0; v1 = 0; ordy4 = 1; ordy1 = 1;
      step();
      rst_n = 1; v4 = 1; d4 = 8'h01;
      step();
      d4 = 8'h02;
      step();
      v4 = 0; saw = 0; sd = '0; se = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ov4) begin
            saw = 1; sd = od4; se = oe4;
         end
         model_tick();
         @(posedge clk);
         #1;
      end
      chk("flush_seen", saw, flush_en);
      chk("flush_od", sd, flush_en ? 32'h00000201 : 32'h0);
      chk("flush_els", se, flush_en ? 3'd2 : 3'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
